// File: rtl/mem_bus_master.sv
// mem_bus_master: clocked initiator for an asynchronous 8-bit scratch memory.
// Turns a single-beat valid/ready request into a SETUP / STROBE / HOLD bus
// cycle and returns completion plus read data on a one-cycle rsp_valid pulse.
// Optional macro MEM_WR_VERIFY_EN adds a readback after every write and
// reports a mismatch on rsp_err.
module mem_bus_master #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  inout  wire  [DATA_W-1:0] mem_data
);

  // Phase counters are reloaded with (length - 1) and count down to zero.
  localparam logic [2:0] SETUP_LD  = 3'(SETUP_CYC - 1);
  localparam logic [2:0] STROBE_LD = 3'(STROBE_CYC - 1);
  localparam logic [2:0] HOLD_LD   = 3'(HOLD_CYC - 1);

`ifdef MEM_WR_VERIFY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_VSETUP, ST_VSTROBE, ST_VHOLD
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD
  } state_t;
`endif

  state_t              state_r, state_s;
  logic [2:0]          cnt_r, cnt_s;
  logic                we_r, we_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s;
  logic                drive_r, drive_s;
  logic                ready_r, ready_s;
  logic                rsp_valid_r, rsp_valid_s;
  logic [DATA_W-1:0]   rdata_r, rdata_s;
  logic                err_r, err_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic                read_r, read_s;
  logic                write_r, write_s;
  logic                last_s;

  assign last_s    = (cnt_r == 3'd0);
  assign mem_data  = drive_r ? wdata_r : {DATA_W{1'bz}};
  assign req_ready = ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;
  assign mem_addr  = addr_r;
  assign mem_read  = read_r;
  assign mem_write = write_r;

  // Next-state and next-output logic; all outputs hold unless a phase boundary changes them.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    we_s        = we_r;
    wdata_s     = wdata_r;
    drive_s     = drive_r;
    ready_s     = ready_r;
    rsp_valid_s = 1'b0;
    rdata_s     = rdata_r;
    err_s       = err_r;
    addr_s      = addr_r;
    read_s      = read_r;
    write_s     = write_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && ready_r) begin
          state_s = ST_SETUP;
          cnt_s   = SETUP_LD;
          we_s    = req_we;
          wdata_s = req_wdata;
          addr_s  = req_addr;
          drive_s = req_we;
          ready_s = 1'b0;
        end else begin
          ready_s = 1'b1;
        end
      end
      ST_SETUP: begin
        if (last_s) begin
          state_s = ST_STROBE;
          cnt_s   = STROBE_LD;
          read_s  = ~we_r;
          write_s = we_r;
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
      ST_STROBE: begin
        if (last_s) begin
          state_s = ST_HOLD;
          cnt_s   = HOLD_LD;
          read_s  = 1'b0;
          write_s = 1'b0;
          rdata_s = we_r ? wdata_r : mem_data;
          err_s   = 1'b0;
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
      ST_HOLD: begin
        if (last_s) begin
          drive_s = 1'b0;
`ifdef MEM_WR_VERIFY_EN
          if (we_r) begin
            state_s = ST_VSETUP;
            cnt_s   = 3'd0;
          end else begin
            state_s     = ST_IDLE;
            rsp_valid_s = 1'b1;
            ready_s     = 1'b1;
          end
`else
          state_s     = ST_IDLE;
          rsp_valid_s = 1'b1;
          ready_s     = 1'b1;
`endif
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
`ifdef MEM_WR_VERIFY_EN
      // Bus is already released; one idle cycle lets the write data decay before read.
      ST_VSETUP: begin
        state_s = ST_VSTROBE;
        cnt_s   = STROBE_LD;
        read_s  = 1'b1;
      end
      ST_VSTROBE: begin
        if (last_s) begin
          state_s = ST_VHOLD;
          cnt_s   = HOLD_LD;
          read_s  = 1'b0;
          rdata_s = mem_data;
          err_s   = (mem_data != wdata_r);
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
      ST_VHOLD: begin
        if (last_s) begin
          state_s     = ST_IDLE;
          rsp_valid_s = 1'b1;
          ready_s     = 1'b1;
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 3'd0;
        drive_s = 1'b0;
        ready_s = 1'b1;
        read_s  = 1'b0;
        write_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops strobes and releases the bus at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      we_r        <= 1'b0;
      wdata_r     <= {DATA_W{1'b0}};
      drive_r     <= 1'b0;
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rdata_r     <= {DATA_W{1'b0}};
      err_r       <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      read_r      <= 1'b0;
      write_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      we_r        <= we_s;
      wdata_r     <= wdata_s;
      drive_r     <= drive_s;
      ready_r     <= ready_s;
      rsp_valid_r <= rsp_valid_s;
      rdata_r     <= rdata_s;
      err_r       <= err_s;
      addr_r      <= addr_s;
      read_r      <= read_s;
      write_r     <= write_s;
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: u0 uses default timing with a memory model
// (bit 0 stuck at 0 when MEM_WR_VERIFY_EN is defined); u1 uses
// SETUP=2/STROBE=3/HOLD=1 with a plain memory model.
module tb_mem_bus_master;

`ifdef MEM_WR_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif
  localparam int LAT_W0 = (VER != 0) ? 7 : 4;   // default write latency
  localparam int LAT_T1 = (VER != 0) ? 12 : 7;  // u1 write latency

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  logic req_valid0, req_ready0, req_we0, rsp_valid0, rsp_err0, mem_read0, mem_write0;
  logic [4:0] req_addr0, mem_addr0;
  logic [7:0] req_wdata0, rsp_rdata0;
  tri1  [7:0] mem_data0;
  logic req_valid1, req_ready1, req_we1, rsp_valid1, rsp_err1, mem_read1, mem_write1;
  logic [4:0] req_addr1, mem_addr1;
  logic [7:0] req_wdata1, rsp_rdata1;
  tri1  [7:0] mem_data1;

  logic [7:0] mem0 [32];
  logic [7:0] mem1 [32];

  int checks = 0;
  int errors = 0;
  int rsp_cnt0 = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  mem_bus_master u0 (
    .clk(clk), .rst(rst0), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .mem_addr(mem_addr0), .mem_read(mem_read0), .mem_write(mem_write0),
    .mem_data(mem_data0)
  );

  mem_bus_master #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1)) u1 (
    .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
    .mem_addr(mem_addr1), .mem_read(mem_read1), .mem_write(mem_write1),
    .mem_data(mem_data1)
  );

  function automatic logic [7:0] stuck(input logic [7:0] d);
    if (VER != 0) return d & 8'hFE;
    else return d;
  endfunction

  // Memory models: asynchronous read drive, write captured while strobe is high.
  assign mem_data0 = mem_read0 ? mem0[mem_addr0] : 8'hzz;
  assign mem_data1 = mem_read1 ? mem1[mem_addr1] : 8'hzz;

  always @(posedge clk) begin
    if (mem_write0) mem0[mem_addr0] <= stuck(mem_data0);
    if (mem_write1) mem1[mem_addr1] <= mem_data1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  // Scoreboard consumers: pop the expected response on every rsp_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid0) begin
      rsp_cnt0++;
      if (sb0.size() == 0) tmo("rsp0_unexpected");
      else begin
        e = sb0.pop_front();
        chk("rsp0_rdata", 32'(rsp_rdata0), 32'(e.rdata));
        chk("rsp0_err", 32'(rsp_err0), 32'(e.err));
      end
    end
    if (rsp_valid1) begin
      if (sb1.size() == 0) tmo("rsp1_unexpected");
      else begin
        e = sb1.pop_front();
        chk("rsp1_rdata", 32'(rsp_rdata1), 32'(e.rdata));
        chk("rsp1_err", 32'(rsp_err1), 32'(e.err));
      end
    end
  end

  task automatic drive0(input vec_t v);
    req_we0 = v.we;
    req_addr0 = v.addr;
    req_wdata0 = v.wdata;
  endtask

  task automatic req0(input vec_t v);
    int n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!req_ready0 && n < 64) begin @(negedge clk); n++; end
    if (!req_ready0) tmo("req0_ready");
    drive0(v);
    req_valid0 = 1'b1;
    e.rdata = v.exp_rdata;
    e.err = v.exp_err;
    sb0.push_back(e);
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    n = 0;
    while (!rsp_valid0 && n < 64) begin @(negedge clk); n++; end
    if (!rsp_valid0) tmo("req0_rsp");
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] a, input logic [7:0] d, input logic [7:0] stored);
    vec_t v;
    v.we = we;
    v.addr = a;
    v.wdata = d;
    v.exp_rdata = we ? stuck(d) : stored;
    v.exp_err = we ? (stuck(d) != d) : 1'b0;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    vec_t bb[4];
    exp_t e;
    int n, acc, since, lat, base, reads;

    // Vector table: fill 0..31, read back 0..31, then the stuck-bit pair on addr 2.
    for (int i = 0; i < 32; i++) vecs.push_back(mk(1'b1, 5'(i), 8'(i), 8'h00));
    for (int i = 0; i < 32; i++) vecs.push_back(mk(1'b0, 5'(i), 8'h00, stuck(8'(i))));
    vecs.push_back(mk(1'b1, 5'h02, 8'h01, 8'h00));
    vecs.push_back(mk(1'b1, 5'h02, 8'h02, 8'h00));
    vecs.push_back(mk(1'b0, 5'h02, 8'h00, 8'h02));
    bb[0] = mk(1'b1, 5'h10, 8'h3C, 8'h00);
    bb[1] = mk(1'b0, 5'h11, 8'h00, stuck(8'h11));
    bb[2] = mk(1'b1, 5'h12, 8'h4B, 8'h00);
    bb[3] = mk(1'b0, 5'h13, 8'h00, stuck(8'h13));

    rst0 = 1'b1; rst1 = 1'b1;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 5'h00; req_wdata0 = 8'h00;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = 5'h00; req_wdata1 = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst_ready", 32'(req_ready0), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata0), 32'd0);
    chk("rst_err", 32'(rsp_err0), 32'd0);
    chk("rst_addr", 32'(mem_addr0), 32'd0);
    chk("rst_read", 32'(mem_read0), 32'd0);
    chk("rst_write", 32'(mem_write0), 32'd0);
    chk("rst_data_z", 32'(mem_data0), 32'hFF);
    rst0 = 1'b0; rst1 = 1'b0;

    // Fill and check, then the extra table entries.
    base = rsp_cnt0;
    for (int i = 0; i < 64; i++) req0(vecs[i]);
    @(negedge clk);
    chk("fill_pulses", 32'(rsp_cnt0 - base), 32'd64);
    for (int i = 64; i < vecs.size(); i++) req0(vecs[i]);

    // Timing on u1: write 0x5A to 0x03, trace the bus cycle by cycle.
    @(negedge clk);
    req_we1 = 1'b1; req_addr1 = 5'h03; req_wdata1 = 8'h5A; req_valid1 = 1'b1;
    chk("t_ready", 32'(req_ready1), 32'd1);
    e.rdata = 8'h5A; e.err = 1'b0;
    sb1.push_back(e);
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    for (int k = 1; k <= LAT_T1; k++) begin
      @(negedge clk);
      chk($sformatf("t_write_k%0d", k), 32'(mem_write1), 32'((k >= 3) && (k <= 5)));
      chk($sformatf("t_rsp_k%0d", k), 32'(rsp_valid1), 32'(k == LAT_T1));
      if (k <= 6) begin
        chk($sformatf("t_data_k%0d", k), 32'(mem_data1), 32'h5A);
        chk($sformatf("t_addr_k%0d", k), 32'(mem_addr1), 32'h03);
      end
    end

    // Turnaround on u1: read addr 3; the master's latched wdata differs from memory.
    @(negedge clk);
    req_we1 = 1'b0; req_addr1 = 5'h03; req_wdata1 = 8'hA5; req_valid1 = 1'b1;
    e.rdata = 8'h5A; e.err = 1'b0;
    sb1.push_back(e);
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    reads = 0;
    n = 0;
    while (!rsp_valid1 && n < 40) begin
      @(negedge clk);
      n++;
      if (mem_read1) begin
        reads++;
        chk("turn_data", 32'(mem_data1), 32'h5A);
        chk("turn_no_x", 32'($isunknown(mem_data1)), 32'd0);
        chk("turn_no_write", 32'(mem_write1), 32'd0);
      end
    end
    if (!rsp_valid1) tmo("turn_rsp");
    chk("turn_strobe_len", 32'(reads), 32'd3);

    // Back-to-back on u0 with req_valid held high.
    @(negedge clk);
    acc = 0; since = 0; lat = 0;
    drive0(bb[0]);
    req_valid0 = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (acc > 0) begin
        chk("b2b_ready", 32'(req_ready0), 32'(since == lat));
        chk("b2b_rsp_cycle", 32'(rsp_valid0), 32'(since == lat));
      end
      if (acc == 4 && since == lat) break;
      if (acc == 0 || since == lat) begin
        e.rdata = bb[acc].exp_rdata; e.err = bb[acc].exp_err;
        sb0.push_back(e);
        lat = bb[acc].we ? LAT_W0 : 4;
        acc++;
        since = 0;
        @(posedge clk);
        #1;
        if (acc < 4) drive0(bb[acc]);
        else req_valid0 = 1'b0;
      end
      @(negedge clk);
      since++;
    end
    if (!(acc == 4 && since == lat)) tmo("b2b_done");

    // Reset in the middle of a write strobe to 0x1F.
    @(negedge clk);
    req_we0 = 1'b1; req_addr0 = 5'h1F; req_wdata0 = 8'h77; req_valid0 = 1'b1;
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    n = 0;
    while (!mem_write0 && n < 20) begin @(negedge clk); n++; end
    if (!mem_write0) tmo("rst_mid_strobe");
    #2 rst0 = 1'b1;
    #1;
    chk("rmid_write", 32'(mem_write0), 32'd0);
    chk("rmid_data_z", 32'(mem_data0), 32'hFF);
    chk("rmid_ready", 32'(req_ready0), 32'd1);
    chk("rmid_read", 32'(mem_read0), 32'd0);
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rmid_no_rsp", 32'(rsp_valid0), 32'd0);
    end
    chk("rmid_rdata_clr", 32'(rsp_rdata0), 32'd0);
    chk("sb0_empty", 32'(sb0.size()), 32'd0);
    chk("sb1_empty", 32'(sb1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
